// File: rtl/rnd_harvester_if.sv
// rnd_harvester_if
//   Byte delivery channel of the entropy harvester.
//   data_out   : harvested byte, stable while data_valid is high
//   data_valid : data_out holds an unconsumed byte
//   data_ready : consumer accepts the byte (transfer on valid & ready)
//   master modport is the harvester side, slave modport the consumer side.
interface rnd_harvester_if;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;

    modport master (
        output data_out,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/rnd_harvester.sv
// rnd_harvester
//   Entropy reader for the ring-oscillator random bank. Synchronizes the
//   asynchronous raw bus, XOR-folds it to one bit per unfrozen cycle,
//   von-Neumann debiases the fold bits, packs accepted bits MSB-first into
//   bytes and hands them out over a valid/ready channel. A repetition-count
//   test on the raw fold bits raises a sticky advisory flag.
// Ports
//   clk         : system clock
//   rst         : asynchronous active-high reset
//   raw_in      : N raw generator bits, asynchronous to clk
//   freeze      : 1 = pause sampling (handshake keeps running)
//   clr         : synchronous clear of harvesting state and sticky flags
//   bus         : byte output channel (data_out / data_valid / data_ready)
//   overflow    : sticky, a completed byte was dropped
//   health_fail : sticky, repetition-count test tripped
module rnd_harvester #(
    parameter int N         = 16,
    parameter int RCT_LIMIT = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           raw_in,
    input  logic                   freeze,
    input  logic                   clr,
    rnd_harvester_if.master        bus,
    output logic                   overflow,
    output logic                   health_fail
);

    localparam int                 RCT_W   = $clog2(RCT_LIMIT + 1);
    localparam logic [RCT_W-1:0]   RCT_MAX = RCT_W'(RCT_LIMIT);
    localparam logic [RCT_W-1:0]   RCT_ONE = RCT_W'(1);

    typedef enum logic {
        PH_FIRST,
        PH_SECOND
    } phase_t;

    // Synchronizer; stage 1 may be metastable and feeds only stage 2.
    logic [N-1:0]     sync1_q;
    logic [N-1:0]     sync2_q;

    phase_t           phase_q;
    logic             a_q;
    // Only the first seven bits of a byte are stored; the eighth is a_q
    // itself at completion, so the byte is {shreg_q, a_q}.
    logic [6:0]       shreg_q;
    logic [6:0]       shreg_d;
    logic [2:0]       cnt_q;
    logic [RCT_W-1:0] rct_q;
    logic [RCT_W-1:0] rct_d;
    logic             prev_f_q;
    logic [7:0]       data_out_q;
    logic             data_valid_q;
    logic             overflow_q;
    logic             health_q;

    logic             fold;
    logic             sample;
    logic             accept;
    logic             byte_done;
    logic             xfer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        fold      = ^sync2_q;
        sample    = ~freeze;
        accept    = sample && (phase_q == PH_SECOND) && (fold != a_q);
        byte_done = accept && (cnt_q == 3'd7);
        shreg_d   = {shreg_q[5:0], a_q};
        xfer      = data_valid_q && bus.data_ready;

        // rct_q == 0 marks "no sample since reset/clr": load 1.
        rct_d = rct_q;
        if ((rct_q == '0) || (fold != prev_f_q)) begin
            rct_d = RCT_ONE;
        end else if (rct_q != RCT_MAX) begin
            rct_d = rct_q + RCT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q      <= PH_FIRST;
            a_q          <= 1'b0;
            shreg_q      <= '0;
            cnt_q        <= '0;
            rct_q        <= '0;
            prev_f_q     <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            health_q     <= 1'b0;
        end else if (clr) begin
            phase_q      <= PH_FIRST;
            cnt_q        <= '0;
            rct_q        <= '0;
            data_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            health_q     <= 1'b0;
        end else begin
            if (sample) begin
                case (phase_q)
                    PH_FIRST: begin
                        a_q     <= fold;
                        phase_q <= PH_SECOND;
                    end
                    PH_SECOND: begin
                        phase_q <= PH_FIRST;
                        if (accept) begin
                            shreg_q <= shreg_d;
                            cnt_q   <= cnt_q + 3'd1;
                        end
                    end
                    default: phase_q <= PH_FIRST;
                endcase

                rct_q    <= rct_d;
                prev_f_q <= fold;
                if (rct_d == RCT_MAX) begin
                    health_q <= 1'b1;
                end
            end

            // A same-edge transfer frees the register, so a completing
            // byte loads instead of being dropped.
            if (byte_done) begin
                if (!data_valid_q || xfer) begin
                    data_out_q   <= {shreg_q, a_q};
                    data_valid_q <= 1'b1;
                end else begin
                    overflow_q <= 1'b1;
                end
            end else if (xfer) begin
                data_valid_q <= 1'b0;
            end
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign overflow       = overflow_q;
    assign health_fail    = health_q;

endmodule
